// File: rtl/tl_arb_mux.sv
// tl_arb_mux: N-master to 1-slave TileLink-UL/UH A/D channel arbiter-multiplexer.
//
// A channel: round-robin arbitration with the grant locked across multi-beat
// messages and across stalled beats. The winner's fields pass to the slave
// combinationally. The master index is prepended to a_source.
// D channel: stateless. Responses are steered back using the index field that
// was prepended to the source.
//
// Parameters: NUM_M masters (2..8), AW address bits, DW data bits, SZW size
//   bits, AIW master source bits, DIW sink bits. MIW is the derived master
//   index width.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   m_a_*                 flattened per-master A channels (master i in slice i)
//   m_d_*                 per-master D valid/ready, shared D payload
//   s_a_*                 slave A channel, s_a_source = {index, master source}
//   s_d_*                 slave D channel
//   d_src_err             sticky out-of-range D index flag (only when
//                         TL_ARB_DSRC_CHECK_EN is defined)
// Macro TL_ARB_DSRC_CHECK_EN: drain D beats whose index has no master and flag them.
module tl_arb_mux #(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 64,
  parameter int unsigned SZW   = 4,
  parameter int unsigned AIW   = 4,
  parameter int unsigned DIW   = 1,
  localparam int unsigned MIW  = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_M-1:0]          m_a_valid,
  output logic [NUM_M-1:0]          m_a_ready,
  input  logic [NUM_M*3-1:0]        m_a_opcode,
  input  logic [NUM_M*3-1:0]        m_a_param,
  input  logic [NUM_M*SZW-1:0]      m_a_size,
  input  logic [NUM_M*AIW-1:0]      m_a_source,
  input  logic [NUM_M*AW-1:0]       m_a_address,
  input  logic [NUM_M*(DW/8)-1:0]   m_a_mask,
  input  logic [NUM_M*DW-1:0]       m_a_data,
  input  logic [NUM_M-1:0]          m_a_corrupt,
  output logic [NUM_M-1:0]          m_d_valid,
  input  logic [NUM_M-1:0]          m_d_ready,
  output logic [3:0]                m_d_opcode,
  output logic [1:0]                m_d_param,
  output logic [SZW-1:0]            m_d_size,
  output logic [AIW-1:0]            m_d_source,
  output logic [DIW-1:0]            m_d_sink,
  output logic                      m_d_denied,
  output logic                      m_d_corrupt,
  output logic [DW-1:0]             m_d_data,
  output logic                      s_a_valid,
  input  logic                      s_a_ready,
  output logic [2:0]                s_a_opcode,
  output logic [2:0]                s_a_param,
  output logic [SZW-1:0]            s_a_size,
  output logic [AIW+MIW-1:0]        s_a_source,
  output logic [AW-1:0]             s_a_address,
  output logic [DW/8-1:0]           s_a_mask,
  output logic [DW-1:0]             s_a_data,
  output logic                      s_a_corrupt,
  input  logic                      s_d_valid,
  output logic                      s_d_ready,
  input  logic [3:0]                s_d_opcode,
  input  logic [1:0]                s_d_param,
  input  logic [SZW-1:0]            s_d_size,
  input  logic [AIW+MIW-1:0]        s_d_source,
  input  logic [DIW-1:0]            s_d_sink,
  input  logic                      s_d_denied,
  input  logic                      s_d_corrupt,
`ifdef TL_ARB_DSRC_CHECK_EN
  input  logic [DW-1:0]             s_d_data,
  output logic                      d_src_err
`else
  input  logic [DW-1:0]             s_d_data
`endif
);

  localparam int unsigned MW     = DW / 8;
  localparam int unsigned LOG_BW = $clog2(MW);
  localparam int unsigned BCW    = (SZW >= 5) ? 32 : (1 << SZW);

  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

  state_t           state, state_nxt;
  logic [MIW-1:0]   rr_ptr, rr_nxt;
  logic [MIW-1:0]   gnt, gnt_nxt;
  logic [BCW-1:0]   beats_left, beats_left_nxt;
  logic [MIW-1:0]   win;
  logic [MIW-1:0]   sel;
  logic             sel_valid;
  logic             fire;
  logic [BCW-1:0]   beats;
  logic [MIW-1:0]   d_idx;
  logic             d_idx_ok;
  logic             d_rdy_sel;
  int               scan_j;

  function automatic logic [MIW-1:0] rr_inc(input logic [MIW-1:0] x);
    return (32'(x) == NUM_M - 1) ? '0 : x + MIW'(1);
  endfunction

  // Round-robin scan starting at rr_ptr; the lowest offset is written last and wins.
  always_comb begin
    win    = '0;
    scan_j = 0;
    for (int k = int'(NUM_M) - 1; k >= 0; k--) begin
      scan_j = int'(rr_ptr) + k;
      if (scan_j >= int'(NUM_M)) scan_j = scan_j - int'(NUM_M);
      if (m_a_valid[scan_j]) win = MIW'(scan_j);
    end
  end

  // Outside IDLE only the locked master is connected.
  assign sel       = (state == IDLE) ? win : gnt;
  assign sel_valid = (state == IDLE) ? (|m_a_valid) : m_a_valid[sel];

  assign s_a_opcode  = m_a_opcode[32'(sel)*3 +: 3];
  assign s_a_param   = m_a_param[32'(sel)*3 +: 3];
  assign s_a_size    = m_a_size[32'(sel)*SZW +: SZW];
  assign s_a_source  = {sel, m_a_source[32'(sel)*AIW +: AIW]};
  assign s_a_address = m_a_address[32'(sel)*AW +: AW];
  assign s_a_mask    = m_a_mask[32'(sel)*MW +: MW];
  assign s_a_data    = m_a_data[32'(sel)*DW +: DW];
  assign s_a_corrupt = m_a_corrupt[sel];

  assign s_a_valid = rst_n & sel_valid;
  assign fire      = s_a_valid & s_a_ready;

  // Data-carrying opcodes (0..3) span several beats once size exceeds the bus width.
  assign beats = (!s_a_opcode[2] && (s_a_size > SZW'(LOG_BW)))
               ? (BCW'(1) << (s_a_size - SZW'(LOG_BW)))
               : BCW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt        <= '0;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      gnt        <= gnt_nxt;
      beats_left <= beats_left_nxt;
    end
  end

  // Next-state and A-channel ready steering.
  always_comb begin
    state_nxt      = state;
    rr_nxt         = rr_ptr;
    gnt_nxt        = gnt;
    beats_left_nxt = beats_left;
    m_a_ready      = '0;
    if (rst_n && s_a_ready) m_a_ready[sel] = 1'b1;
    case (state)
      IDLE, HOLD: begin
        if (fire) begin
          if (beats > BCW'(1)) begin
            gnt_nxt        = sel;
            beats_left_nxt = beats - BCW'(1);
            state_nxt      = BURST;
          end else begin
            rr_nxt    = rr_inc(sel);
            state_nxt = IDLE;
          end
        end else if (sel_valid) begin
          // A presented beat pins the grant until it is accepted.
          gnt_nxt   = sel;
          state_nxt = HOLD;
        end
      end
      BURST: begin
        if (fire) begin
          beats_left_nxt = beats_left - BCW'(1);
          if (beats_left == BCW'(1)) begin
            rr_nxt    = rr_inc(gnt);
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // D channel: steer by the index field carried in every beat's source.
  assign d_idx    = s_d_source[AIW+MIW-1:AIW];
  assign d_idx_ok = 32'(d_idx) < NUM_M;

  always_comb begin
    m_d_valid = '0;
    d_rdy_sel = 1'b0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (d_idx == MIW'(i)) begin
        m_d_valid[i] = rst_n & s_d_valid;
        d_rdy_sel    = m_d_ready[i];
      end
    end
  end

`ifdef TL_ARB_DSRC_CHECK_EN
  assign s_d_ready = rst_n & (d_idx_ok ? d_rdy_sel : 1'b1);

  // Sticky flag for drained beats addressed to a non-existent master.
  always_ff @(posedge clk) begin
    if (!rst_n) d_src_err <= 1'b0;
    else if (s_d_valid && !d_idx_ok) d_src_err <= 1'b1;
  end
`else
  assign s_d_ready = rst_n & d_idx_ok & d_rdy_sel;
`endif

  assign m_d_opcode  = s_d_opcode;
  assign m_d_param   = s_d_param;
  assign m_d_size    = s_d_size;
  assign m_d_source  = s_d_source[AIW-1:0];
  assign m_d_sink    = s_d_sink;
  assign m_d_denied  = s_d_denied;
  assign m_d_corrupt = s_d_corrupt;
  assign m_d_data    = s_d_data;

endmodule

// File: tb/tb_tl_arb_mux.sv
// Testbench for tl_arb_mux: 3 masters, 64-bit data. Per-master beat queues feed
// the A ports, hand-ordered expectations are checked by A and D monitors.
module tb_tl_arb_mux;

  localparam int unsigned NUM_M = 3;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned SZW   = 4;
  localparam int unsigned AIW   = 4;
  localparam int unsigned DIW   = 1;
  localparam int unsigned MIW   = 2;
  localparam int unsigned SW    = AIW + MIW;
  localparam int unsigned MW    = DW / 8;

  typedef struct packed {
    logic [2:0]     opcode;
    logic [SZW-1:0] size;
    logic [AIW-1:0] source;
    logic [AW-1:0]  address;
    logic [DW-1:0]  data;
  } beat_t;

  typedef struct packed {
    logic [MIW-1:0] m;
    beat_t          b;
  } exp_a_t;

  typedef struct packed {
    logic [NUM_M-1:0] vld;
    logic [AIW-1:0]   src;
    logic [DW-1:0]    data;
  } exp_d_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_M-1:0]        m_a_valid, m_a_ready;
  logic [NUM_M*3-1:0]      m_a_opcode, m_a_param;
  logic [NUM_M*SZW-1:0]    m_a_size;
  logic [NUM_M*AIW-1:0]    m_a_source;
  logic [NUM_M*AW-1:0]     m_a_address;
  logic [NUM_M*MW-1:0]     m_a_mask;
  logic [NUM_M*DW-1:0]     m_a_data;
  logic [NUM_M-1:0]        m_a_corrupt;
  logic [NUM_M-1:0]        m_d_valid, m_d_ready;
  logic [3:0]              m_d_opcode;
  logic [1:0]              m_d_param;
  logic [SZW-1:0]          m_d_size;
  logic [AIW-1:0]          m_d_source;
  logic [DIW-1:0]          m_d_sink;
  logic                    m_d_denied, m_d_corrupt;
  logic [DW-1:0]           m_d_data;
  logic                    s_a_valid, s_a_ready;
  logic [2:0]              s_a_opcode, s_a_param;
  logic [SZW-1:0]          s_a_size;
  logic [SW-1:0]           s_a_source;
  logic [AW-1:0]           s_a_address;
  logic [MW-1:0]           s_a_mask;
  logic [DW-1:0]           s_a_data;
  logic                    s_a_corrupt;
  logic                    s_d_valid, s_d_ready;
  logic [3:0]              s_d_opcode;
  logic [1:0]              s_d_param;
  logic [SZW-1:0]          s_d_size;
  logic [SW-1:0]           s_d_source;
  logic [DIW-1:0]          s_d_sink;
  logic                    s_d_denied, s_d_corrupt;
  logic [DW-1:0]           s_d_data;
`ifdef TL_ARB_DSRC_CHECK_EN
  logic                    d_src_err;
`endif

  tl_arb_mux #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .SZW(SZW), .AIW(AIW), .DIW(DIW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
    .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
    .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
    .m_a_corrupt(m_a_corrupt),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
    .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_source(m_d_source),
    .m_d_sink(m_d_sink), .m_d_denied(m_d_denied), .m_d_corrupt(m_d_corrupt),
    .m_d_data(m_d_data),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_a_corrupt(s_a_corrupt),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
    .s_d_sink(s_d_sink), .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt),
`ifdef TL_ARB_DSRC_CHECK_EN
    .s_d_data(s_d_data), .d_src_err(d_src_err)
`else
    .s_d_data(s_d_data)
`endif
  );

  beat_t            mq [NUM_M][$];
  exp_a_t           exp_a [$];
  exp_d_t           exp_d [$];
  logic [NUM_M-1:0] fired = '0;
  int               n_checks = 0;
  int               n_err = 0;
  exp_a_t           ea;
  exp_d_t           ed;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic beat_t mk(input logic [2:0] op, input logic [SZW-1:0] sz,
                               input logic [AIW-1:0] src, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data);
    beat_t b;
    b.opcode = op; b.size = sz; b.source = src; b.address = addr; b.data = data;
    return b;
  endfunction

  task automatic push_exp(input logic [MIW-1:0] m, input beat_t b);
    exp_a_t e;
    e.m = m; e.b = b;
    exp_a.push_back(e);
  endtask

  // Master-side driver: retire the beat accepted at this edge, present the next.
  always @(negedge clk) fired = m_a_valid & m_a_ready;

  initial begin
    m_a_valid = '0; m_a_opcode = '0; m_a_param = '0; m_a_size = '0;
    m_a_source = '0; m_a_address = '0; m_a_mask = '1; m_a_data = '0; m_a_corrupt = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < int'(NUM_M); i++) begin
        if (fired[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (mq[i].size() > 0) begin
          m_a_valid[i]              = 1'b1;
          m_a_opcode[3*i +: 3]      = mq[i][0].opcode;
          m_a_size[SZW*i +: SZW]    = mq[i][0].size;
          m_a_source[AIW*i +: AIW]  = mq[i][0].source;
          m_a_address[AW*i +: AW]   = mq[i][0].address;
          m_a_data[DW*i +: DW]      = mq[i][0].data;
        end else begin
          m_a_valid[i] = 1'b0;
        end
      end
    end
  end

  // A monitor: every accepted slave beat must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && s_a_valid && s_a_ready) begin
      if (exp_a.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL a_unexpected_beat: got source %0h, expected no beat", s_a_source);
      end else begin
        ea = exp_a.pop_front();
        chk("a_source",  128'(s_a_source),  128'({ea.m, ea.b.source}));
        chk("a_address", 128'(s_a_address), 128'(ea.b.address));
        chk("a_opcode",  128'(s_a_opcode),  128'(ea.b.opcode));
        chk("a_size",    128'(s_a_size),    128'(ea.b.size));
        chk("a_data",    128'(s_a_data),    128'(ea.b.data));
        chk("a_ready_onehot", 128'(m_a_ready), 128'(3'b001 << ea.m));
      end
    end
  end

  // D monitor: every accepted slave D beat must be steered as expected.
  always @(negedge clk) begin
    if (rst_n && s_d_valid && s_d_ready) begin
      if (exp_d.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL d_unexpected_beat: got source %0h, expected no beat", s_d_source);
      end else begin
        ed = exp_d.pop_front();
        chk("d_valid",  128'(m_d_valid),  128'(ed.vld));
        chk("d_source", 128'(m_d_source), 128'(ed.src));
        chk("d_data",   128'(m_d_data),   128'(ed.data));
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  function automatic bit a_done();
    bit d = (exp_a.size() == 0);
    for (int i = 0; i < int'(NUM_M); i++) if (mq[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_a(input string name, input bit toggle);
    for (int c = 0; c < 200; c++) begin
      if (a_done()) return;
      if (toggle) s_a_ready = (c % 2) == 1;
      step();
    end
    n_checks++; n_err++;
    $display("FAIL %s_timeout: got %0d beats pending, expected 0", name, exp_a.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_a_ready = 1'b1;
    s_d_valid = 1'b0; s_d_opcode = 4'd1; s_d_param = '0; s_d_size = 4'd5;
    s_d_source = '0; s_d_sink = '0; s_d_denied = 1'b0; s_d_corrupt = 1'b0; s_d_data = '0;
    m_d_ready = '0;

    // Reset with every master requesting and a D beat offered.
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < int'(NUM_M); i++) begin
        mq[i].push_back(mk(3'd4, 4'd3, AIW'(4*i + j), AW'(32'h1000*(i+1) + 8*j), DW'(64'hA0 + 16*i + j)));
        push_exp(MIW'(i), mk(3'd4, 4'd3, AIW'(4*i + j), AW'(32'h1000*(i+1) + 8*j), DW'(64'hA0 + 16*i + j)));
      end
    s_d_valid = 1'b1; s_d_source = 6'h11; m_d_ready = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_s_a_valid", 128'(s_a_valid), 128'(0));
      chk("rst_m_a_ready", 128'(m_a_ready), 128'(0));
      chk("rst_m_d_valid", 128'(m_d_valid), 128'(0));
      chk("rst_s_d_ready", 128'(s_d_ready), 128'(0));
      step();
    end
    s_d_valid = 1'b0; m_d_ready = '0;
    rst_n = 1'b1;
    // Round robin from m0: 0,1,2,0,1,2.
    wait_a("round_robin", 1'b0);

    // Burst lock: m0 Get, m1 4-beat PutFullData, m2 Get, m0 Get; ready toggles.
    mq[0].push_back(mk(3'd4, 4'd3, 4'h1, 32'h2000, 64'h0));
    mq[0].push_back(mk(3'd4, 4'd3, 4'h2, 32'h2008, 64'h0));
    for (int k = 0; k < 4; k++) mq[1].push_back(mk(3'd0, 4'd5, 4'h7, AW'(32'h3000 + 8*k), DW'(64'hB0 + k)));
    mq[2].push_back(mk(3'd4, 4'd3, 4'h2, 32'h4000, 64'h0));
    push_exp(2'd0, mk(3'd4, 4'd3, 4'h1, 32'h2000, 64'h0));
    for (int k = 0; k < 4; k++) push_exp(2'd1, mk(3'd0, 4'd5, 4'h7, AW'(32'h3000 + 8*k), DW'(64'hB0 + k)));
    push_exp(2'd2, mk(3'd4, 4'd3, 4'h2, 32'h4000, 64'h0));
    push_exp(2'd0, mk(3'd4, 4'd3, 4'h2, 32'h2008, 64'h0));
    wait_a("burst_lock", 1'b1);
    s_a_ready = 1'b1;

    // Hold: rr_ptr now favours m1, but m0's unaccepted beat keeps the grant.
    s_a_ready = 1'b0;
    mq[0].push_back(mk(3'd4, 4'd3, 4'h3, 32'h5000, 64'h0));
    push_exp(2'd0, mk(3'd4, 4'd3, 4'h3, 32'h5000, 64'h0));
    push_exp(2'd1, mk(3'd4, 4'd3, 4'h4, 32'h6000, 64'h0));
    for (int c = 0; c < 5; c++) begin
      if (c == 1) mq[1].push_back(mk(3'd4, 4'd3, 4'h4, 32'h6000, 64'h0));
      step();
      @(negedge clk);
      chk("hold_s_a_valid", 128'(s_a_valid), 128'(1));
      chk("hold_grant_idx", 128'(s_a_source[SW-1:AIW]), 128'(0));
      chk("hold_m_a_ready", 128'(m_a_ready), 128'(0));
    end
    step();
    s_a_ready = 1'b1;
    wait_a("hold", 1'b0);

    // D routing: 4 beats to m2 with its ready pulsed; other masters ready.
    s_d_valid = 1'b1; s_d_opcode = 4'd1; s_d_source = 6'h2A; m_d_ready = 3'b011;
    for (int b = 0; b < 4; b++) begin
      s_d_data = DW'(64'hD000 + b);
      m_d_ready[2] = 1'b0;
      @(negedge clk);
      chk("d_stall_s_d_ready", 128'(s_d_ready), 128'(0));
      chk("d_stall_m_d_valid", 128'(m_d_valid), 128'(3'b100));
      chk("d_stall_m_d_source", 128'(m_d_source), 128'(4'hA));
      step();
      m_d_ready[2] = 1'b1;
      exp_d.push_back({3'b100, 4'hA, DW'(64'hD000 + b)});
      @(negedge clk);
      chk("d_go_s_d_ready", 128'(s_d_ready), 128'(1));
      step();
    end
    // One beat to m0.
    s_d_source = 6'h03; s_d_data = 64'hE0; m_d_ready = 3'b001;
    exp_d.push_back({3'b001, 4'h3, 64'hE0});
    step();
    s_d_valid = 1'b0;
    chk("d_scoreboard_drained", 128'(exp_d.size()), 128'(0));

    // D beat with index 3 (no such master).
    s_d_valid = 1'b1; s_d_source = 6'h35; s_d_data = 64'hF0; m_d_ready = '1;
`ifdef TL_ARB_DSRC_CHECK_EN
    exp_d.push_back({3'b000, 4'h5, 64'hF0});
    @(negedge clk);
    chk("srcchk_s_d_ready", 128'(s_d_ready), 128'(1));
    chk("srcchk_m_d_valid", 128'(m_d_valid), 128'(0));
    chk("srcchk_err_before", 128'(d_src_err), 128'(0));
    step();
    s_d_valid = 1'b0;
    @(negedge clk);
    chk("srcchk_err_set", 128'(d_src_err), 128'(1));
    step(); step(); step();
    chk("srcchk_err_sticky", 128'(d_src_err), 128'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("srcchk_err_cleared", 128'(d_src_err), 128'(0));
`else
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("srcchk_s_d_ready", 128'(s_d_ready), 128'(0));
      chk("srcchk_m_d_valid", 128'(m_d_valid), 128'(0));
      step();
    end
    s_d_valid = 1'b0;
`endif
    step();
    chk("a_scoreboard_drained", 128'(exp_a.size()), 128'(0));
    chk("d_scoreboard_empty", 128'(exp_d.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
